// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: the hazard inputs and the pipeline-register control outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned width      = 32,
  parameter int unsigned reg_addr_w = 5
);
  logic                  imem_resp_i;
  logic                  dmem_op_i;
  logic                  dmem_resp_i;
  logic [reg_addr_w-1:0] id_rs1_i;
  logic [reg_addr_w-1:0] id_rs2_i;
  logic [reg_addr_w-1:0] ex_rd_i;
  logic                  ex_is_load_i;
  logic                  ex_redirect_i;

  logic                  pc_load_o;
  logic                  if_id_load_o;
  logic                  id_ex_load_o;
  logic                  ex_mem_load_o;
  logic                  mem_wb_load_o;
  logic                  if_id_flush_o;
  logic                  id_ex_flush_o;
  logic                  mem_wb_flush_o;
  logic [1:0]            state_o;
  logic [width-1:0]      stall_cnt_o;
  logic [width-1:0]      flush_cnt_o;

  // Pipeline side: drives hazard status, receives register controls.
  modport master (
    output imem_resp_i, dmem_op_i, dmem_resp_i, id_rs1_i, id_rs2_i,
           ex_rd_i, ex_is_load_i, ex_redirect_i,
    input  pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o,
           if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, state_o,
           stall_cnt_o, flush_cnt_o
  );

  // Controller side.
  modport slave (
    input  imem_resp_i, dmem_op_i, dmem_resp_i, id_rs1_i, id_rs2_i,
           ex_rd_i, ex_is_load_i, ex_redirect_i,
    output pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o,
           if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, state_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage pipeline: resolves I-miss, D-stall, load-use
// and EX redirects into PC / pipeline-register load and flush controls, and
// tracks wrong-path fetches still in flight across a redirect.
module pipeline_hazard_ctrl #(
  parameter int unsigned width      = 32,
  parameter int unsigned reg_addr_w = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int unsigned cnt_w = width;
  localparam logic [cnt_w-1:0] cnt_max = '1;
  localparam logic [reg_addr_w-1:0] reg_zero = '0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IWAIT  = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [cnt_w-1:0] stall_cnt_q;
  logic [cnt_w-1:0] flush_cnt_q;

  logic dstall, lu, redir, fetch_ok;
  logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic if_id_flush, id_ex_flush, mem_wb_flush;

  // Hazard conditions; a stalled MEM stage freezes everything, including redirects.
  always_comb begin
    dstall   = bus.dmem_op_i & ~bus.dmem_resp_i;
    lu       = bus.ex_is_load_i & (bus.ex_rd_i != reg_zero) &
               ((bus.ex_rd_i == bus.id_rs1_i) | (bus.ex_rd_i == bus.id_rs2_i));
    redir    = bus.ex_redirect_i & ~dstall;
    fetch_ok = bus.imem_resp_i & (state_q != SQUASH);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next state and prioritized register controls (dstall > redir > lu > fetch stall).
  always_comb begin
    state_d      = state_q;
    pc_load      = 1'b1;
    if_id_load   = 1'b1;
    id_ex_load   = 1'b1;
    ex_mem_load  = 1'b1;
    mem_wb_load  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    // Fetch tracking runs independently of data stalls.
    unique case (state_q)
      RUN: begin
        if (!bus.imem_resp_i && redir) state_d = SQUASH;
        else if (!bus.imem_resp_i)     state_d = IWAIT;
      end
      IWAIT: begin
        if (bus.imem_resp_i) state_d = RUN;
        else if (redir)      state_d = SQUASH;
      end
      SQUASH: begin
        if (bus.imem_resp_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (dstall) begin
      // Freeze; bubble into WB so the stalled instruction is not written back twice.
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redir) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (lu) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_flush  = 1'b1;
    end else if (!fetch_ok) begin
      // No valid fetched word (miss or wrong-path response): hold PC, bubble IF/ID.
      pc_load      = 1'b0;
      if_id_flush  = 1'b1;
    end

    if (!rst) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_load && stall_cnt_q != cnt_max) stall_cnt_q <= stall_cnt_q + cnt_w'(1);
      if (redir && flush_cnt_q != cnt_max)    flush_cnt_q <= flush_cnt_q + cnt_w'(1);
    end
  end

  // Drive the bus.
  always_comb begin
    bus.pc_load_o      = pc_load;
    bus.if_id_load_o   = if_id_load;
    bus.id_ex_load_o   = id_ex_load;
    bus.ex_mem_load_o  = ex_mem_load;
    bus.mem_wb_load_o  = mem_wb_load;
    bus.if_id_flush_o  = if_id_flush;
    bus.id_ex_flush_o  = id_ex_flush;
    bus.mem_wb_flush_o = mem_wb_flush;
    bus.state_o        = state_q;
    bus.stall_cnt_o    = stall_cnt_q;
    bus.flush_cnt_o    = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with 4-bit counters covers saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       imem_resp = 1'b1;
  logic       dmem_op = 1'b0;
  logic       dmem_resp = 1'b0;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic [4:0] rd = '0;
  logic       is_load = 1'b0;
  logic       redirect = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.width(32), .reg_addr_w(5)) bus ();
  pipeline_hazard_ctrl_if #(.width(4),  .reg_addr_w(5)) bus4 ();

  assign bus.imem_resp_i   = imem_resp;
  assign bus.dmem_op_i     = dmem_op;
  assign bus.dmem_resp_i   = dmem_resp;
  assign bus.id_rs1_i      = rs1;
  assign bus.id_rs2_i      = rs2;
  assign bus.ex_rd_i       = rd;
  assign bus.ex_is_load_i  = is_load;
  assign bus.ex_redirect_i = redirect;

  assign bus4.imem_resp_i   = imem_resp;
  assign bus4.dmem_op_i     = dmem_op;
  assign bus4.dmem_resp_i   = dmem_resp;
  assign bus4.id_rs1_i      = rs1;
  assign bus4.id_rs2_i      = rs2;
  assign bus4.ex_rd_i       = rd;
  assign bus4.ex_is_load_i  = is_load;
  assign bus4.ex_redirect_i = redirect;

  pipeline_hazard_ctrl #(.width(32), .reg_addr_w(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_hazard_ctrl #(.width(4), .reg_addr_w(5)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb} loads and {if_id, id_ex, mem_wb} flushes.
  wire [4:0] loads   = {bus.pc_load_o, bus.if_id_load_o, bus.id_ex_load_o,
                        bus.ex_mem_load_o, bus.mem_wb_load_o};
  wire [2:0] flushes = {bus.if_id_flush_o, bus.id_ex_flush_o, bus.mem_wb_flush_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [4:0] l, input logic [2:0] f, input logic [1:0] s);
    chk({tag, " loads"},   32'(loads),       32'(l));
    chk({tag, " flushes"}, 32'(flushes),     32'(f));
    chk({tag, " state"},   32'(bus.state_o), 32'(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_resp = 1'b1; dmem_op = 1'b0; dmem_resp = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; is_load = 1'b0; redirect = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state, before any clock edge.
    #1;
    ctl("reset", 5'b00000, 3'b111, 2'd0);
    chk("reset stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("reset flush_cnt", bus.flush_cnt_o, 32'd0);
    #1 rst = 1'b1;
    #1;
    ctl("normal", 5'b11111, 3'b000, 2'd0);
    tick();

    // Load-use on rs2, then x0 destination, then rs1.
    is_load = 1'b1; rd = 5'd5; rs2 = 5'd5; #1;
    ctl("lu rs2", 5'b00111, 3'b010, 2'd0);
    tick();
    chk("lu stall_cnt", bus.stall_cnt_o, 32'd1);
    rd = 5'd0; rs2 = 5'd0; #1;
    ctl("lu x0", 5'b11111, 3'b000, 2'd0);
    tick();
    chk("lu x0 stall_cnt", bus.stall_cnt_o, 32'd1);
    rd = 5'd7; rs1 = 5'd7; rs2 = 5'd3; #1;
    ctl("lu rs1", 5'b00111, 3'b010, 2'd0);
    tick();
    chk("lu rs1 stall_cnt", bus.stall_cnt_o, 32'd2);

    // Data stall for 3 cycles with a redirect that must be ignored.
    do_reset();
    dmem_op = 1'b1; dmem_resp = 1'b0; redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      ctl("dstall", 5'b00000, 3'b001, 2'd0);
      tick();
    end
    chk("dstall flush_cnt", bus.flush_cnt_o, 32'd0);
    chk("dstall stall_cnt", bus.stall_cnt_o, 32'd3);
    dmem_resp = 1'b1; redirect = 1'b0; #1;
    ctl("dstall done", 5'b11111, 3'b000, 2'd0);
    tick();
    chk("dstall done stall_cnt", bus.stall_cnt_o, 32'd3);

    // Redirect in RUN beats a simultaneous load-use.
    do_reset();
    redirect = 1'b1; is_load = 1'b1; rd = 5'd9; rs1 = 5'd9; #1;
    ctl("redir over lu", 5'b11111, 3'b110, 2'd0);
    tick();
    chk("redir flush_cnt", bus.flush_cnt_o, 32'd1);
    chk("redir stall_cnt", bus.stall_cnt_o, 32'd0);

    // I-miss for 4 cycles.
    do_reset();
    imem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      ctl("imiss", 5'b01111, 3'b100, (i == 0) ? 2'd0 : 2'd1);
      tick();
    end
    imem_resp = 1'b1; #1;
    ctl("imiss resp", 5'b11111, 3'b000, 2'd1);
    tick();
    ctl("imiss after", 5'b11111, 3'b000, 2'd0);
    chk("imiss stall_cnt", bus.stall_cnt_o, 32'd4);

    // Redirect during a miss, response two cycles later.
    do_reset();
    imem_resp = 1'b0; tick();
    redirect = 1'b1; #1;
    ctl("redir in iwait", 5'b11111, 3'b110, 2'd1);
    tick();
    redirect = 1'b0; #1;
    ctl("squash wait", 5'b01111, 3'b100, 2'd2);
    chk("squash flush_cnt", bus.flush_cnt_o, 32'd1);
    tick();
    imem_resp = 1'b1; #1;
    ctl("squash resp", 5'b01111, 3'b100, 2'd2);
    tick();
    ctl("squash done", 5'b11111, 3'b000, 2'd0);
    chk("squash stall_cnt", bus.stall_cnt_o, 32'd3);

    // Second redirect while squashing keeps SQUASH and loads the PC.
    do_reset();
    imem_resp = 1'b0; tick();
    redirect = 1'b1; tick();
    #1;
    ctl("redir in squash", 5'b11111, 3'b110, 2'd2);
    tick();
    chk("redir2 state", 32'(bus.state_o), 32'd2);
    chk("redir2 flush_cnt", bus.flush_cnt_o, 32'd2);

    // Saturation on the 4-bit instance, then asynchronous reset mid-SQUASH.
    do_reset();
    imem_resp = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat stall_cnt w4", 32'(bus4.stall_cnt_o), 32'd15);
    chk("sat stall_cnt w32", bus.stall_cnt_o, 32'd20);
    redirect = 1'b1; tick();
    redirect = 1'b0;
    chk("pre-reset state", 32'(bus.state_o), 32'd2);
    chk("pre-reset flush_cnt w4", 32'(bus4.flush_cnt_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    ctl("async reset", 5'b00000, 3'b111, 2'd0);
    chk("async reset stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("async reset flush_cnt", bus.flush_cnt_o, 32'd0);
    chk("async reset stall_cnt w4", 32'(bus4.stall_cnt_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC.
- Each cycle it decides which registers load, hold or flush. Inputs it resolves:
  - instruction-memory misses
  - data-memory stalls
  - load-use hazards
  - taken-branch/jump redirects from EX
- Tracks outstanding wrong-path fetches across a redirect and keeps saturating stall/flush performance counters.

Parameters:
- width, 32, performance counter width
- reg_addr_w, 5, register-specifier width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- imem_resp_i  in  1  fetch of current PC completes this cycle
- dmem_op_i  in  1  MEM stage holds a load/store
- dmem_resp_i  in  1  data memory completes this cycle
- id_rs1_i  in  reg_addr_w  ID source register 1
- id_rs2_i  in  reg_addr_w  ID source register 2
- ex_rd_i  in  reg_addr_w  EX destination register
- ex_is_load_i  in  1  EX instruction is a load
- ex_redirect_i  in  1  EX resolved taken branch/jal/jalr
- pc_load_o  out  1  PC register load enable
- if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o  out  1 each  pipeline register load enables
- if_id_flush_o, id_ex_flush_o, mem_wb_flush_o  out  1 each  insert bubble (zero) into register
- state_o  out  2  FSM state (RUN=0, IWAIT=1, SQUASH=2)
- stall_cnt_o  out  width  cycles with pc_load_o=0
- flush_cnt_o  out  width  accepted redirects

Behaviour:
- **Reset.** rst low asynchronously forces:
  - state=RUN, both counters 0
  - all *_load_o=0, all *_flush_o=1
- Outputs are combinational from state and inputs when rst is high.

- **Conditions:**
  - dstall = dmem_op_i & ~dmem_resp_i
  - lu = ex_is_load_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i)
  - redir = ex_redirect_i & ~dstall
  - fetch_ok = imem_resp_i & state!=SQUASH

- **Priority:** dstall > redir > lu > fetch stall. Default is all loads=1, flushes=0.

- **dstall:**
  - all loads=0, mem_wb_flush_o=1 (bubble into WB, no double writeback)
  - any imem response this cycle is discarded; PC held, so it refetches
- **redir:**
  - pc_load_o=1 (target), if_id_flush_o=1, id_ex_flush_o=1
  - EX/MEM/WB load normally; flush_cnt++
- **lu:**
  - pc_load_o=0, if_id_load_o=0, id_ex_flush_o=1
  - EX_MEM and MEM_WB load; exactly 1 bubble per hazard
- **Fetch stall** (~fetch_ok, none of the above):
  - pc_load_o=0, if_id_flush_o=1
  - downstream loads normally
- x0 never causes lu.

- **FSM transitions:**
  - RUN:
    - ~imem_resp_i & redir -> SQUASH
    - ~imem_resp_i -> IWAIT
    - else RUN
  - IWAIT:
    - imem_resp_i -> RUN (redir same cycle: fetched word already flushed, PC takes target)
    - ~imem_resp_i & redir -> SQUASH
    - else IWAIT
  - SQUASH (in-flight fetch is wrong-path):
    - on imem_resp_i: if_id_flush_o=1, pc_load_o=0 unless redir, -> RUN
    - another redir while waiting: pc_load_o=1, stay SQUASH
- dstall does not block FSM transitions; imem progress is tracked independently.

- **Counters:**
  - stall_cnt_o +1 each cycle pc_load_o=0
  - flush_cnt_o +1 per redir
  - both saturate at all-ones and never wrap

- **Reset mid-miss:** state returns to RUN; the outstanding fetch is the memory model's responsibility.

Test Plan:
- **Load-use.** ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, imem_resp_i=1:
  - one cycle: pc_load_o=0, if_id_load_o=0, id_ex_flush_o=1
  - stall_cnt_o=1
  - repeat with ex_rd_i=0 -> no stall
- **Data stall.** dmem_op_i=1, dmem_resp_i=0 for 3 cycles then 1:
  - 3 cycles of all loads=0 and mem_wb_flush_o=1
  - ex_redirect_i=1 during stall is ignored (flush_cnt_o stays 0)
  - stall_cnt_o=3
- **I-miss.** imem_resp_i=0 for 4 cycles:
  - state_o=1 from cycle 2
  - if_id_flush_o=1 and pc_load_o=0 each cycle
  - resp -> state_o=0, normal loads
- **Redirect during miss.** In IWAIT, ex_redirect_i=1:
  - pc_load_o=1, if_id_flush_o=1, id_ex_flush_o=1, state_o=2
  - resp 2 cycles later -> if_id_flush_o=1, pc_load_o=0, state_o=0
  - flush_cnt_o=1
- **Saturation/reset.**
  - width=4: 20 stall cycles -> stall_cnt_o=15
  - assert rst mid-SQUASH -> state_o=0, counters 0, loads 0, flushes 1 immediately (before clk edge)
